// File: rtl/lc2k_multicycle_ctrl.sv
// LC2K multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB over a unified memory port.
// Define LC2K_PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module lc2k_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_WIDTH   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] instr_opcode,
    input  logic       alu_eq,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_load,
    output logic       pc_load,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic       reg_dst,
    output logic [1:0] reg_wdata_sel,
    output logic       alu_b_sel,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic       mem_err,
    output logic [2:0] state_dbg
`ifdef LC2K_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instr_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NOR  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_JALR = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    localparam logic [31:0] TMO_LAST = 32'(MEM_TIMEOUT - 1);

    state_t      state;
    state_t      next;
    logic [31:0] tmo_cnt;
    logic        wait_last;
    logic        tmo_fire;

    // A ready arriving on the final allowed cycle still wins over the timeout.
    assign wait_last = (MEM_TIMEOUT > 0) && !mem_ready && (tmo_cnt == TMO_LAST);
    assign state_dbg = state;

    always_comb begin
        next          = state;
        tmo_fire      = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_load       = 1'b0;
        pc_load       = 1'b0;
        pc_src        = 2'd0;
        reg_we        = 1'b0;
        reg_dst       = 1'b0;
        reg_wdata_sel = 2'd0;
        alu_b_sel     = 1'b0;
        alu_op        = 2'b00;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_load = 1'b1;
                        next    = S_DECODE;
                    end else if (wait_last) begin
                        tmo_fire = 1'b1;
                        next     = S_HALTED;
                    end
                end
                S_DECODE: next = S_EXEC;
                S_EXEC: begin
                    case (instr_opcode)
                        OP_ADD, OP_NOR: begin
                            alu_b_sel = 1'b1;
                            alu_op    = (instr_opcode == OP_NOR) ? 2'b01 : 2'b00;
                            next      = S_WB;
                        end
                        OP_LW, OP_SW: next = S_MEM;
                        OP_BEQ: begin
                            alu_b_sel = 1'b1;
                            alu_op    = 2'b10;
                            pc_load   = 1'b1;
                            pc_src    = alu_eq ? 2'd1 : 2'd0;
                            next      = S_FETCH;
                        end
                        OP_JALR: begin
                            reg_we        = 1'b1;
                            reg_wdata_sel = 2'd2;
                            pc_load       = 1'b1;
                            pc_src        = 2'd2;
                            next          = S_FETCH;
                        end
                        OP_HALT: begin
                            pc_load = 1'b1;
                            next    = S_HALTED;
                        end
                        default: begin
                            pc_load = 1'b1;
                            next    = S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (instr_opcode == OP_SW);
                    if (mem_ready) begin
                        if (instr_opcode == OP_SW) begin
                            pc_load = 1'b1;
                            next    = S_FETCH;
                        end else begin
                            next = S_WB;
                        end
                    end else if (wait_last) begin
                        tmo_fire = 1'b1;
                        next     = S_HALTED;
                    end
                end
                S_WB: begin
                    reg_we  = 1'b1;
                    pc_load = 1'b1;
                    if (instr_opcode == OP_ADD || instr_opcode == OP_NOR) begin
                        reg_dst   = 1'b1;
                        alu_b_sel = 1'b1;
                        alu_op    = (instr_opcode == OP_NOR) ? 2'b01 : 2'b00;
                    end else begin
                        reg_wdata_sel = 2'd1;
                    end
                    next = S_FETCH;
                end
                S_HALTED: next = S_HALTED;
                default:  next = S_HALTED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            tmo_cnt <= '0;
            halted  <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            state  <= next;
            halted <= (next == S_HALTED);
            if (tmo_fire)
                mem_err <= 1'b1;
            if (next != state && (next == S_FETCH || next == S_MEM))
                tmo_cnt <= '0;
            else if (mem_req && !mem_ready)
                tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

`ifdef LC2K_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state != S_HALTED)
                cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            if (pc_load)
                instr_cnt <= instr_cnt + CNT_WIDTH'(1);
        end
    end
`else
    logic [CNT_WIDTH-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_lc2k_multicycle_ctrl.sv
// Bench for lc2k_multicycle_ctrl: per-instruction expected traces built from the
// opcode/state rules, driven cycle by cycle with randomized waits and don't-care inputs.
module tb_lc2k_multicycle_ctrl;
    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] instr_opcode = 3'd0;
    logic       alu_eq = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_addr_sel, ir_load, pc_load;
    logic [1:0] pc_src;
    logic       reg_we, reg_dst;
    logic [1:0] reg_wdata_sel;
    logic       alu_b_sel;
    logic [1:0] alu_op;
    logic       halted, mem_err;
    logic [2:0] state_dbg;
`ifdef LC2K_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    lc2k_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .instr_opcode(instr_opcode),
        .alu_eq(alu_eq), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
        .pc_load(pc_load), .pc_src(pc_src), .reg_we(reg_we),
        .reg_dst(reg_dst), .reg_wdata_sel(reg_wdata_sel),
        .alu_b_sel(alu_b_sel), .alu_op(alu_op), .halted(halted),
        .mem_err(mem_err), .state_dbg(state_dbg)
`ifdef LC2K_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, asel, irl, pcl;
        logic [1:0] pcs;
        logic       rwe, rdst;
        logic [1:0] wsel;
        logic       bsel;
        logic [1:0] aop;
        logic       hlt, err;
    } obs_t;

    typedef struct {
        logic       rst;
        logic [2:0] op;
        logic       rdy;
        logic       eq;
        obs_t       exp;
        obs_t       mask;
    } cyc_t;

    localparam obs_t ALL = '1;

    cyc_t tr[$];
    int   total = 0;
    int   bad = 0;
    obs_t got;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] rop();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic void push(logic rst, logic [2:0] op, logic rdy,
                                 logic eq, obs_t e, obs_t m);
        cyc_t c;
        c.rst = rst; c.op = op; c.rdy = rdy; c.eq = eq;
        c.exp = e; c.mask = m;
        tr.push_back(c);
    endfunction

    // First reset cycle still shows the pre-reset registered state.
    function automatic void push_rst(int n);
        obs_t m;
        for (int i = 0; i < n; i++) begin
            m = ALL;
            if (i == 0) begin
                m.st = '0; m.hlt = 1'b0; m.err = 1'b0;
            end
            push(1'b1, rop(), rbit(), rbit(), '0, m);
        end
    endfunction

    function automatic void push_halted(int n, logic err);
        obs_t e;
        e = '0; e.st = 3'd5; e.hlt = 1'b1; e.err = err;
        for (int i = 0; i < n; i++)
            push(1'b0, rop(), rbit(), rbit(), e, ALL);
    endfunction

    // Returns 0: back in FETCH, 1: halt executed, 2: memory timeout.
    function automatic int add_instr(logic [2:0] op, logic eq, int fw, int mw);
        obs_t e;
        for (int i = 0; i <= fw; i++) begin
            if (i == TMO) return 2;
            e = '0; e.req = 1'b1; e.irl = (i == fw);
            push(1'b0, rop(), i == fw, rbit(), e, ALL);
        end
        e = '0; e.st = 3'd1;
        push(1'b0, op, rbit(), rbit(), e, ALL);
        e = '0; e.st = 3'd2;
        case (op)
            3'd0: e.bsel = 1'b1;
            3'd1: begin e.bsel = 1'b1; e.aop = 2'b01; end
            3'd4: begin
                e.bsel = 1'b1; e.aop = 2'b10; e.pcl = 1'b1;
                e.pcs = {1'b0, eq};
            end
            3'd5: begin
                e.rwe = 1'b1; e.wsel = 2'd2; e.pcl = 1'b1; e.pcs = 2'd2;
            end
            3'd6, 3'd7: e.pcl = 1'b1;
            default: ;
        endcase
        push(1'b0, op, rbit(), eq, e, ALL);
        if (op == 3'd6) return 1;
        if (op >= 3'd4) return 0;
        if (op == 3'd2 || op == 3'd3) begin
            for (int i = 0; i <= mw; i++) begin
                if (i == TMO) return 2;
                e = '0; e.st = 3'd3; e.req = 1'b1; e.asel = 1'b1;
                e.we = (op == 3'd3);
                e.pcl = (op == 3'd3) && (i == mw);
                push(1'b0, op, i == mw, rbit(), e, ALL);
            end
            if (op == 3'd3) return 0;
        end
        e = '0; e.st = 3'd4; e.rwe = 1'b1; e.pcl = 1'b1;
        if (op == 3'd2) begin
            e.wsel = 2'd1;
        end else begin
            e.rdst = 1'b1; e.bsel = 1'b1; e.aop = {1'b0, op[0]};
        end
        push(1'b0, op, rbit(), rbit(), e, ALL);
        return 0;
    endfunction

    task automatic step(input cyc_t c, output obs_t o);
        @(negedge clk);
        reset = c.rst;
        instr_opcode = c.op;
        mem_ready = c.rdy;
        alu_eq = c.eq;
        #1;
        o = {state_dbg, mem_req, mem_we, mem_addr_sel, ir_load, pc_load,
             pc_src, reg_we, reg_dst, reg_wdata_sel, alu_b_sel, alu_op,
             halted, mem_err};
    endtask

    task automatic test_reset();
        obs_t e, m;
        tr.delete();
        push_rst(2);
        e = '0; e.req = 1'b1;
        push(1'b0, rop(), 1'b0, 1'b0, e, ALL);
        m = ALL; m.st = '0;
        push(1'b1, rop(), 1'b1, 1'b0, '0, m);
        void'(add_instr(3'd7, 1'b0, 0, 0));
        foreach (tr[i]) begin
            step(tr[i], got);
            total++;
            if ((got & tr[i].mask) !== (tr[i].exp & tr[i].mask)) begin
                bad++;
                $display("FAIL reset cyc %0d: got %h want %h", i, got, tr[i].exp);
            end
        end
    endtask

    task automatic test_add_nor();
        tr.delete();
        push_rst(2);
        void'(add_instr(3'd0, 1'b0, 0, 0));
        void'(add_instr(3'd1, 1'b1, 0, 0));
        void'(add_instr(3'd0, 1'b0, 2, 0));
        foreach (tr[i]) begin
            step(tr[i], got);
            total++;
            if ((got & tr[i].mask) !== (tr[i].exp & tr[i].mask)) begin
                bad++;
                $display("FAIL add_nor cyc %0d: got %h want %h", i, got, tr[i].exp);
            end
        end
    endtask

    task automatic test_lw_sw_delay();
        tr.delete();
        push_rst(2);
        void'(add_instr(3'd2, 1'b0, 0, 3));
        void'(add_instr(3'd3, 1'b0, 1, 2));
        void'(add_instr(3'd2, 1'b1, 0, 0));
        foreach (tr[i]) begin
            step(tr[i], got);
            total++;
            if ((got & tr[i].mask) !== (tr[i].exp & tr[i].mask)) begin
                bad++;
                $display("FAIL lw_sw cyc %0d: got %h want %h", i, got, tr[i].exp);
            end
        end
    endtask

    task automatic test_beq();
        tr.delete();
        push_rst(2);
        void'(add_instr(3'd4, 1'b1, 0, 0));
        void'(add_instr(3'd4, 1'b0, 0, 0));
        void'(add_instr(3'd4, 1'b1, 1, 0));
        foreach (tr[i]) begin
            step(tr[i], got);
            total++;
            if ((got & tr[i].mask) !== (tr[i].exp & tr[i].mask)) begin
                bad++;
                $display("FAIL beq cyc %0d: got %h want %h", i, got, tr[i].exp);
            end
        end
    endtask

    task automatic test_jalr_halt();
        tr.delete();
        push_rst(2);
        void'(add_instr(3'd5, rbit(), 0, 0));
        void'(add_instr(3'd6, rbit(), 0, 0));
        push_halted(10, 1'b0);
        push_rst(2);
        void'(add_instr(3'd7, 1'b0, 0, 0));
        foreach (tr[i]) begin
            step(tr[i], got);
            total++;
            if ((got & tr[i].mask) !== (tr[i].exp & tr[i].mask)) begin
                bad++;
                $display("FAIL jalr_halt cyc %0d: got %h want %h", i, got, tr[i].exp);
            end
        end
    endtask

    task automatic test_timeout();
        tr.delete();
        push_rst(2);
        void'(add_instr(3'd0, 1'b0, TMO, 0));
        push_halted(3, 1'b1);
        push_rst(2);
        void'(add_instr(3'd0, 1'b0, TMO - 1, 0));
        void'(add_instr(3'd3, 1'b0, 0, TMO - 1));
        void'(add_instr(3'd2, 1'b0, 0, TMO + 1));
        push_halted(3, 1'b1);
        foreach (tr[i]) begin
            step(tr[i], got);
            total++;
            if ((got & tr[i].mask) !== (tr[i].exp & tr[i].mask)) begin
                bad++;
                $display("FAIL timeout cyc %0d: got %h want %h", i, got, tr[i].exp);
            end
        end
    endtask

    task automatic test_random();
        int r, fw, mw;
        tr.delete();
        push_rst(2);
        repeat (60) begin
            fw = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 1)
                                             : $urandom_range(0, 2);
            mw = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 1)
                                             : $urandom_range(0, 3);
            r = add_instr(rop(), rbit(), fw, mw);
            if (r != 0) begin
                push_halted(2, r == 2);
                push_rst(2);
            end
        end
        foreach (tr[i]) begin
            step(tr[i], got);
            total++;
            if ((got & tr[i].mask) !== (tr[i].exp & tr[i].mask)) begin
                bad++;
                $display("FAIL random cyc %0d: got %h want %h", i, got, tr[i].exp);
            end
        end
    endtask

`ifdef LC2K_PERF_CNT_EN
    task automatic test_perf();
        int cyc_m, ins_m;
        tr.delete();
        push_rst(2);
        void'(add_instr(3'd0, 1'b0, 0, 0));
        void'(add_instr(3'd3, 1'b0, 0, 0));
        void'(add_instr(3'd6, 1'b0, 0, 0));
        push_halted(5, 1'b0);
        cyc_m = 0;
        ins_m = 0;
        foreach (tr[i]) begin
            if (!tr[i].rst && tr[i].exp.st != 3'd5) cyc_m++;
            if (!tr[i].rst && tr[i].exp.pcl) ins_m++;
        end
        foreach (tr[i]) begin
            step(tr[i], got);
            if (tr[i].exp.st == 3'd5) begin
                total++;
                if (cycle_cnt !== 32'(cyc_m)) begin
                    bad++;
                    $display("FAIL perf cycle_cnt cyc %0d: got %0d want %0d",
                             i, cycle_cnt, cyc_m);
                end
                total++;
                if (instr_cnt !== 32'(ins_m)) begin
                    bad++;
                    $display("FAIL perf instr_cnt cyc %0d: got %0d want %0d",
                             i, instr_cnt, ins_m);
                end
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_add_nor();
        test_lw_sw_delay();
        test_beq();
        test_jalr_halt();
        test_timeout();
        test_random();
`ifdef LC2K_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc2k_multicycle_ctrl.md
Name: lc2k_multicycle_ctrl

Overview:
Multi-cycle sequencer for the LC2K core. It replaces per-opcode combinational decode with an FSM that steps one instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the PC, IR, register file, ALU and a shared unified memory port through a req/ready handshake. It sits between the instruction register and the datapath muxes.

Parameters:
MEM_TIMEOUT, 0, max cycles to wait for mem_ready per access; 0 = no timeout.
CNT_WIDTH, 32, width of performance counters (used only with the optional feature).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous active-high reset
instr_opcode  in  3  IR[24:22]; valid from DECODE onward
alu_eq  in  1  ALU equality flag (regA == regB), valid in EXEC
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  1 = write, 0 = read
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_load  out  1  load IR from memory read data
pc_load  out  1  update PC this cycle
pc_src  out  2  0 = PC+1, 1 = PC+1+offset, 2 = regA value
reg_we  out  1  register file write enable
reg_dst  out  1  1 = destReg, 0 = regB
reg_wdata_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+1
alu_b_sel  out  1  1 = regB value, 0 = sign-extended offset
alu_op  out  2  00 add, 01 nor, 10 equality compare
halted  out  1  core stopped (HALT executed or timeout)
mem_err  out  1  memory timeout occurred
state_dbg  out  3  current FSM state encoding

Behaviour:
- Opcodes: 000 add, 001 nor, 010 lw, 011 sw, 100 beq, 101 jalr, 110 halt, 111 noop.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5. Encodings 6/7 are illegal and go to HALTED with mem_err=0.
- Reset: state <= FETCH, timeout counter <= 0, halted <= 0, mem_err <= 0. While reset is high, all combinational outputs are forced to 0. Reset mid-access drops mem_req the same cycle; a pending mem_ready is ignored.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0. On mem_ready: ir_load=1, go to DECODE. Otherwise stay.
- DECODE: one cycle, no side-effect outputs, go to EXEC.
- EXEC, by opcode:
  - add/nor: alu_b_sel=1, alu_op=00 or 01, go to WB.
  - lw/sw: alu_b_sel=0, alu_op=00, go to MEM.
  - beq: alu_b_sel=1, alu_op=10, pc_load=1, pc_src = alu_eq ? 1 : 0, go to FETCH.
  - jalr: reg_we=1, reg_dst=0, reg_wdata_sel=2, pc_load=1, pc_src=2, go to FETCH. Register write and PC update happen on the same edge, so regA==regB yields PC=old regA.
  - halt: pc_load=1, pc_src=0, go to HALTED.
  - noop: pc_load=1, pc_src=0, go to FETCH.
- MEM: mem_req=1, mem_addr_sel=1, alu_b_sel=0, alu_op=00, mem_we=1 for sw. On mem_ready: lw goes to WB; sw asserts pc_load=1, pc_src=0 and goes to FETCH.
- WB: reg_we=1, pc_load=1, pc_src=0.
  - add/nor: reg_dst=1, reg_wdata_sel=0, alu_b_sel=1, alu_op held from EXEC.
  - lw: reg_dst=0, reg_wdata_sel=1.
  - Then go to FETCH.
- HALTED: all outputs 0 except halted=1, mem_err (sticky) and state_dbg. Left only by reset.
- Handshake rules:
  - mem_req, mem_we and mem_addr_sel are stable from assertion until the cycle mem_ready is sampled high.
  - mem_ready while mem_req=0 is ignored.
  - Each access completes in one cycle minimum.
- Timeout (MEM_TIMEOUT>0):
  - The counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still low: mem_err <= 1, go to HALTED.
  - mem_ready arriving on the same cycle the count reaches MEM_TIMEOUT wins; the access completes normally.
- Latency with zero-wait memory: add/nor 4, lw 5, sw 4, beq/jalr/noop 3, halt 3 cycles to HALTED.

Optional Feature:
LC2K_PERF_CNT_EN:
- Defined: adds outputs cycle_cnt and instr_cnt (each CNT_WIDTH).
  - cycle_cnt increments every non-reset cycle while not halted.
  - instr_cnt increments on each pc_load, halt included.
  - Both reset to 0, freeze in HALTED, and wrap modulo 2^CNT_WIDTH.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset for 2 cycles, then release, mem_ready=1 always, opcode=000 → state_dbg sequence 0,1,2,4,0; reg_we=1 and pc_load=1 only in the WB cycle; all outputs 0 during reset.
- lw with mem_ready delayed 3 cycles in MEM → mem_req held with mem_addr_sel=1 for 4 cycles; WB has reg_wdata_sel=1, reg_dst=0.
- beq with alu_eq=1 → pc_src=1; with alu_eq=0 → pc_src=0; pc_load=1 in EXEC; next state FETCH.
- jalr → single EXEC cycle with reg_we=1, reg_wdata_sel=2, pc_src=2; halt → halted=1 and remains 1 for 10 cycles of random opcodes until reset.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH → mem_err=1 and halted=1 after exactly 4 wait cycles; repeat with mem_ready on the 4th cycle → normal DECODE, mem_err=0.
- With LC2K_PERF_CNT_EN: sequence add, sw, halt with zero-wait memory → instr_cnt=3 and cycle_cnt=11, frozen thereafter.
